// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers for the EX stage.
// One shift-add or restoring shift-subtract step per cycle, sign fix-up at the end.
module mult_div_unit #(
    parameter int NB_DATA = 32,
    parameter int NB_OP   = 3,
    parameter int NB_CNT  = 6
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [NB_OP-1:0]   op_i,
    input  logic [NB_DATA-1:0] rs_data_i,
    input  logic [NB_DATA-1:0] rt_data_i,
    input  logic               hilo_rd_i,
    input  logic               flush_i,
    output logic               busy_o,
    output logic               stall_o,
    output logic               done_o,
    output logic [NB_DATA-1:0] hi_o,
    output logic [NB_DATA-1:0] lo_o
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t                 state, state_nxt;
    logic [NB_CNT-1:0]      cnt;
    logic [2*NB_DATA-1:0]   acc;
    logic [NB_DATA-1:0]     opnd;
    logic                   is_div, res_neg, rem_neg;

    logic                   accept, op_md, op_mthi, op_mtlo;
    logic                   rs_neg, rt_neg;
    logic [NB_DATA-1:0]     rs_mag, rt_mag;
    logic [NB_DATA:0]       mul_sum, div_sh, div_diff;
    logic [2*NB_DATA-1:0]   mul_nxt, div_nxt, prod_fix;
    logic [NB_DATA-1:0]     quo, rem, hi_fix, lo_fix;

    assign accept  = start_i & ~flush_i & (state == IDLE);
    assign op_md   = op_i < NB_OP'(4);
    assign op_mthi = op_i == NB_OP'(4);
    assign op_mtlo = op_i == NB_OP'(5);

    // Unsigned ops (odd codes) never take the absolute value.
    assign rs_neg = ~op_i[0] & rs_data_i[NB_DATA-1];
    assign rt_neg = ~op_i[0] & rt_data_i[NB_DATA-1];
    assign rs_mag = rs_neg ? -rs_data_i : rs_data_i;
    assign rt_mag = rt_neg ? -rt_data_i : rt_data_i;

    // acc holds {partial product, multiplier} or {remainder, quotient}.
    assign mul_sum  = {1'b0, acc[2*NB_DATA-1:NB_DATA]}
                    + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_nxt  = {mul_sum, acc[NB_DATA-1:1]};
    assign div_sh   = {acc[2*NB_DATA-1:NB_DATA], acc[NB_DATA-1]};
    assign div_diff = div_sh - {1'b0, opnd};
    assign div_nxt  = div_diff[NB_DATA]
                    ? {div_sh[NB_DATA-1:0], acc[NB_DATA-2:0], 1'b0}
                    : {div_diff[NB_DATA-1:0], acc[NB_DATA-2:0], 1'b1};

    // A zero divisor leaves the dividend magnitude in rem and all-ones quotient.
    assign prod_fix = res_neg ? -acc : acc;
    assign quo      = acc[NB_DATA-1:0];
    assign rem      = acc[2*NB_DATA-1:NB_DATA];
    assign lo_fix   = !is_div ? prod_fix[NB_DATA-1:0]
                    : (opnd == '0) ? '1
                    : res_neg ? -quo : quo;
    assign hi_fix   = !is_div ? prod_fix[2*NB_DATA-1:NB_DATA]
                    : rem_neg ? -rem : rem;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && op_md) state_nxt = RUN;
            RUN: begin
                if (flush_i) begin
                    state_nxt = IDLE;
                end else if (cnt == NB_CNT'(NB_DATA-1)) begin
                    state_nxt = FIX;
                end
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            is_div  <= 1'b0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
            done_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && op_md) begin
                        acc     <= {{NB_DATA{1'b0}}, rs_mag};
                        opnd    <= rt_mag;
                        is_div  <= op_i[1];
                        res_neg <= rs_neg ^ rt_neg;
                        rem_neg <= rs_neg;
                        cnt     <= '0;
                    end else if (accept && op_mthi) begin
                        hi_o <= rs_data_i;
                    end else if (accept && op_mtlo) begin
                        lo_o <= rs_data_i;
                    end
                end
                RUN: begin
                    if (!flush_i) begin
                        acc <= is_div ? div_nxt : mul_nxt;
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    if (!flush_i) begin
                        hi_o   <= hi_fix;
                        lo_o   <= lo_fix;
                        done_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o  = state != IDLE;
    assign stall_o = busy_o & (start_i | hilo_rd_i);

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed scoreboard bench for mult_div_unit: latency, HI/LO results,
// hazard stall, MTxx, flush and reset abort paths.
module tb_mult_div_unit;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  op_i = '0;
    logic [31:0] rs_data_i = '0;
    logic [31:0] rt_data_i = '0;
    logic        hilo_rd_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        busy_o, stall_o, done_o;
    logic [31:0] hi_o, lo_o;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];
    logic [31:0] cur_hi = '0;
    logic [31:0] cur_lo = '0;

    mult_div_unit dut (
        .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i),
        .op_i(op_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
        .hilo_rd_i(hilo_rd_i), .flush_i(flush_i), .busy_o(busy_o),
        .stall_o(stall_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb_l;
        int ia, ib;
        logic [31:0] q, r;
        case (op)
            3'd0: begin
                sa = longint'($signed(a));
                sb_l = longint'($signed(b));
                return 64'(sa * sb_l);
            end
            3'd1: return {32'b0, a} * {32'b0, b};
            3'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return {32'h0, 32'h8000_0000};
                ia = $signed(a);
                ib = $signed(b);
                q = 32'(ia / ib);
                r = 32'(ia % ib);
                return {r, q};
            end
            3'd3: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return {cur_hi, cur_lo};
        endcase
    endfunction

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic rd,
                          input int poke);
        logic [63:0] exp;
        hilo_rd_i = rd;
        start_i = 1'b1;
        op_i = op;
        rs_data_i = a;
        rt_data_i = b;
        sb.push_back(model(op, a, b));
        @(negedge clock_i);
        start_i = 1'b0;
        for (int i = 1; i <= 33; i++) begin
            if (i == poke) begin
                start_i = 1'b1;
                op_i = 3'd4;
                rs_data_i = 32'hDEAD_BEEF;
            end
            #1;
            chk("busy_run", busy_o, 1);
            chk("stall_run", stall_o, (rd || i == poke) ? 1 : 0);
            chk("done_early", done_o, 0);
            @(negedge clock_i);
            start_i = 1'b0;
        end
        chk("done_pulse", done_o, 1);
        chk("busy_done", busy_o, 0);
        chk("stall_done", stall_o, 0);
        if (sb.size() == 0) begin
            chk("sb_empty", 64'(sb.size()), 1);
        end else begin
            exp = sb.pop_front();
            chk("hi", hi_o, exp[63:32]);
            chk("lo", lo_o, exp[31:0]);
            cur_hi = exp[63:32];
            cur_lo = exp[31:0];
        end
        hilo_rd_i = 1'b0;
    endtask

    task automatic quiet();
        @(negedge clock_i);
        chk("done_width", done_o, 0);
        chk("busy_after", busy_o, 0);
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] v,
                      input logic fl);
        start_i = 1'b1;
        op_i = op;
        rs_data_i = v;
        flush_i = fl;
        @(negedge clock_i);
        start_i = 1'b0;
        flush_i = 1'b0;
        if (!fl && op == 3'd4) cur_hi = v;
        if (!fl && op == 3'd5) cur_lo = v;
        chk("mt_hi", hi_o, cur_hi);
        chk("mt_lo", lo_o, cur_lo);
        chk("mt_busy", busy_o, 0);
        chk("mt_done", done_o, 0);
    endtask

    task automatic abort(input logic [2:0] op, input int k,
                         input logic use_rst);
        int dn;
        start_i = 1'b1;
        op_i = op;
        rs_data_i = 32'h0001_2345;
        rt_data_i = 32'h0000_0067;
        @(negedge clock_i);
        start_i = 1'b0;
        repeat (k - 1) @(negedge clock_i);
        chk("abort_busy_pre", busy_o, 1);
        if (use_rst) begin
            reset_i = 1'b0;
            #1;
            cur_hi = '0;
            cur_lo = '0;
            chk("rst_busy", busy_o, 0);
            chk("rst_hi", hi_o, 0);
            chk("rst_lo", lo_o, 0);
            chk("rst_done", done_o, 0);
            @(negedge clock_i);
            reset_i = 1'b1;
        end else begin
            flush_i = 1'b1;
            @(negedge clock_i);
            flush_i = 1'b0;
            chk("flush_busy", busy_o, 0);
        end
        dn = 0;
        repeat (40) begin
            @(negedge clock_i);
            if (done_o) dn++;
        end
        chk("abort_no_done", 64'(dn), 0);
        chk("abort_hi", hi_o, cur_hi);
        chk("abort_lo", lo_o, cur_lo);
    endtask

    initial begin
        #1;
        chk("reset_busy", busy_o, 0);
        chk("reset_done", done_o, 0);
        chk("reset_hi", hi_o, 0);
        chk("reset_lo", lo_o, 0);
        chk("reset_stall", stall_o, 0);
        @(negedge clock_i);
        reset_i = 1'b1;
        @(negedge clock_i);

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1, 0);
        quiet();
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        quiet();
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
        quiet();
        run_op(3'd2, 32'h1234_5678, 32'd0, 1'b0, 0);
        quiet();
        run_op(3'd3, 32'h8765_4321, 32'd0, 1'b0, 0);
        quiet();
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        quiet();
        run_op(3'd0, 32'h0001_2345, 32'hFFFF_6789, 1'b0, 5);
        quiet();
        for (int i = 0; i < 4; i++) begin
            run_op(3'(i), $urandom, $urandom_range(1, 32'hFFFF), 1'b0, 0);
            quiet();
        end

        mt(3'd5, 32'hCAFE_BABE, 1'b0);
        mt(3'd4, 32'h0BAD_F00D, 1'b0);
        mt(3'd6, 32'h5555_AAAA, 1'b0);
        mt(3'd5, 32'h1111_2222, 1'b1);

        abort(3'd2, 10, 1'b0);
        abort(3'd0, 20, 1'b1);

        run_op(3'd1, 32'h0000_FFFF, 32'h0001_0001, 1'b0, 0);
        quiet();
        chk("sb_drained", 64'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the EX stage of the MIPS pipeline. It consumes the forwarded rs/rt operands produced by the EX-stage operand-forwarding muxes and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Results go into the architectural HI/LO registers. While an operation is in flight, the unit raises a stall request toward the hazard logic.

## Interface
Parameters:
- NB_DATA, 32, operand/result width
- NB_OP, 3, operation code width
- NB_CNT, 6, iteration counter width (must hold NB_DATA)

Ports:
- clock_i  in  1  system clock, rising edge
- reset_i  in  1  asynchronous, active-low reset
- start_i  in  1  operation valid in EX this cycle
- op_i  in  NB_OP  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
- rs_data_i  in  NB_DATA  forwarded rs operand (dividend / multiplicand / MTxx source)
- rt_data_i  in  NB_DATA  forwarded rt operand (divisor / multiplier)
- hilo_rd_i  in  1  MFHI/MFLO present in EX this cycle
- flush_i  in  1  kill in-flight operation
- busy_o  out  1  state != IDLE
- stall_o  out  1  combinational: busy_o & (start_i | hilo_rd_i)
- done_o  out  1  one-cycle pulse, HI/LO just updated by MULT/DIV
- hi_o  out  NB_DATA  HI register
- lo_o  out  NB_DATA  LO register

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE + start_i + MULT/MULTU/DIV/DIVU + !flush_i:
  - capture operand magnitudes; signed ops take two's-complement absolute value, unsigned ops pass through
  - record result sign (rs[31]^rt[31]) and remainder sign (rs[31]); both are zero for unsigned ops
  - counter = 0; go to RUN
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
  - After NB_DATA steps (counter == NB_DATA-1), go to FIX.
- FIX: apply sign correction.
  - MULT: 64-bit product negated if result sign set.
  - DIV: quotient negated if result sign set; remainder negated if remainder sign set.
  - Write HI/LO, pulse done_o next cycle, go to IDLE.
- Results:
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient, HI = remainder.
- Divide by zero (rt == 0): normal latency; LO = 32'hFFFF_FFFF, HI = rs_data_i as captured (signed and unsigned).
- DIV 0x8000_0000 / 0xFFFF_FFFF: LO = 0x8000_0000, HI = 0 (magnitude wrap, no trap).
- MTHI/MTLO in IDLE with start_i: HI (or LO) <= rs_data_i at that edge; single cycle; no busy, no done_o.
- Undefined op codes: no effect.
- start_i while busy: ignored. The pipeline holds the instruction via stall_o, and it is accepted the cycle after return to IDLE.
- flush_i in RUN/FIX: return to IDLE next edge; HI/LO unchanged; no done_o.
- flush_i in IDLE with start_i: flush wins, nothing captured, including MTHI/MTLO.

## Timing
- Reset (async, reset_i = 0): state IDLE, counter 0, hi_o = lo_o = 0, busy_o = 0, done_o = 0, internal accumulators 0. Asserting reset mid-RUN aborts immediately; no result written.
- Start accepted at edge E0. busy_o high from E0 until E(NB_DATA+1).
- HI/LO valid after edge E(NB_DATA+1), i.e. 33 cycles for NB_DATA = 32.
- done_o high for exactly the cycle following E(NB_DATA+1).
- An MFHI/MFLO in EX during busy_o stalls (stall_o = 1). In the cycle done_o is high, busy_o = 0, so the read proceeds and sees the new values.
- Back-to-back: a new start_i is accepted in the done_o cycle.
- hi_o/lo_o are registered outputs; they never change except at MTxx, FIX, or reset.

## Test plan
- MULT: rs = 0xFFFF_FFFE (-2), rt = 3 -> after 33 cycles HI = 0xFFFF_FFFF, LO = 0xFFFF_FFFA; done_o one cycle; busy_o high 33 cycles.
- MULTU: rs = 0xFFFF_FFFF, rt = 0xFFFF_FFFF -> HI = 0xFFFF_FFFE, LO = 0x0000_0001.
- DIV: rs = -7 (0xFFFF_FFF9), rt = 2 -> LO = 0xFFFF_FFFD (-3), HI = 0xFFFF_FFFF (-1). DIVU on the same operands -> LO = 0x7FFF_FFFC, HI = 1.
- Division boundaries:
  - DIV by zero with rs = 0x1234_5678 -> LO = 0xFFFF_FFFF, HI = 0x1234_5678.
  - DIV 0x8000_0000 / -1 -> LO = 0x8000_0000, HI = 0.
- Hazards and MTxx:
  - hilo_rd_i held high during MULT -> stall_o = 1 every busy cycle, 0 in the done_o cycle.
  - start_i while busy -> ignored.
  - MTLO 0xCAFE_BABE in IDLE -> lo_o updated next edge, busy_o stays 0.
- Abort paths:
  - flush_i at RUN cycle 10 -> IDLE next edge, HI/LO keep prior values, no done_o.
  - reset_i low at RUN cycle 20 -> immediate IDLE, hi_o = lo_o = 0.
